// File: rtl/mult_share_arb.sv
// mult_share_arb
//
// Round-robin arbiter and sequencer that shares one unsigned multiplier
// between N requesters. The winner's operands are registered at grant. The
// product is captured one cycle later and returned with a one-hot done pulse
// to the owner.
//
// Parameters:
//   WIDTH  operand width in bits (unsigned)
//   N      number of requesters, 2..8
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   req       per-requester request level
//   a_flat    operand A, requester i at [i*WIDTH +: WIDTH]
//   b_flat    operand B, packed the same way as a_flat
//   gnt       one-hot grant pulse, in the cycle after operand capture
//   done      one-hot completion pulse; result is valid in the same cycle
//   result    full 2*WIDTH-bit product, held until the next capture
//   busy      high whenever the FSM is not idle
//   op_count  (only with MULT_SHARE_ARB_CNT_EN) wrapping count of completed
//             operations
//
// Optional feature macro: MULT_SHARE_ARB_CNT_EN adds the op_count port and
// its counter.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting; picks a round-robin winner and captures its operands
// EXEC  | multiplying the captured operands; gnt is high
// RESP  | done and result are presented; ptr advances past the owner

module mult_share_arb #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   a_flat,
  input  logic [N*WIDTH-1:0]   b_flat,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
`ifdef MULT_SHARE_ARB_CNT_EN
  ,
  output logic [15:0]          op_count
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] prod;

  logic               found;
  logic [IW-1:0]      win;
  int                 idx;

  // Round-robin search: ptr, ptr+1, ... N-1, 0, ... first asserted req wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-extend both operands so the product keeps its full width.
  assign prod = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      gnt    <= '0;
      done   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a  <= a_flat[int'(win)*WIDTH +: WIDTH];
            op_b  <= b_flat[int'(win)*WIDTH +: WIDTH];
            owner <= win;
            gnt   <= ONE_HOT0 << win;
          end
        end
        EXEC: begin
          result <= prod;
          done   <= ONE_HOT0 << owner;
          gnt    <= '0;
        end
        RESP: begin
          done <= '0;
          ptr  <= (owner == IW'(N-1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_SHARE_ARB_CNT_EN
  // Counts on the same edge that raises done, so it lines up with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                op_count <= '0;
    else if (state == EXEC) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_flat;
  logic [15:0] b_flat;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  result;
  logic        busy;
`ifdef MULT_SHARE_ARB_CNT_EN
  logic [15:0] op_count;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  mult_share_arb #(.WIDTH(4), .N(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .busy   (busy)
`ifdef MULT_SHARE_ARB_CNT_EN
    ,
    .op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  res;
    logic        busy;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
`ifdef MULT_SHARE_ARB_CNT_EN
    chk(name, 32'(op_count), 32'(exp_cnt));
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  initial begin
    // Full load from reset: a_i = i+2, b_i = i+3, all req held high.
    vecs[0]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0001, 4'b0000, 8'h00, 1'b1};
    vecs[1]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0001, 8'h06, 1'b1};
    vecs[2]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0000, 8'h06, 1'b0};
    vecs[3]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0010, 4'b0000, 8'h06, 1'b1};
    vecs[4]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0010, 8'h0C, 1'b1};
    vecs[5]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0000, 8'h0C, 1'b0};
    vecs[6]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0100, 4'b0000, 8'h0C, 1'b1};
    vecs[7]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0100, 8'h14, 1'b1};
    vecs[8]  = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0000, 8'h14, 1'b0};
    vecs[9]  = '{4'b1111, 16'h5432, 16'h6543, 4'b1000, 4'b0000, 8'h14, 1'b1};
    vecs[10] = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b1000, 8'h1E, 1'b1};
    vecs[11] = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0000, 8'h1E, 1'b0};
    vecs[12] = '{4'b1111, 16'h5432, 16'h6543, 4'b0001, 4'b0000, 8'h1E, 1'b1};
    vecs[13] = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0001, 8'h06, 1'b1};
    vecs[14] = '{4'b1111, 16'h5432, 16'h6543, 4'b0000, 4'b0000, 8'h06, 1'b0};
    // Single request on requester 0: a=2, b=1.
    vecs[15] = '{4'b0001, 16'h0002, 16'h0001, 4'b0001, 4'b0000, 8'h06, 1'b1};
    vecs[16] = '{4'b0000, 16'h0002, 16'h0001, 4'b0000, 4'b0001, 8'h02, 1'b1};
    vecs[17] = '{4'b0000, 16'h0002, 16'h0001, 4'b0000, 4'b0000, 8'h02, 1'b0};
    // Max operands on requester 1; operands cleared after grant.
    vecs[18] = '{4'b0010, 16'h00F0, 16'h00F0, 4'b0010, 4'b0000, 8'h02, 1'b1};
    vecs[19] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 8'hE1, 1'b1};
    vecs[20] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 8'hE1, 1'b0};
    // Serve requester 2 (3*4).
    vecs[21] = '{4'b0100, 16'h0300, 16'h0400, 4'b0100, 4'b0000, 8'hE1, 1'b1};
    vecs[22] = '{4'b0000, 16'h0300, 16'h0400, 4'b0000, 4'b0100, 8'h0C, 1'b1};
    vecs[23] = '{4'b0000, 16'h0300, 16'h0400, 4'b0000, 4'b0000, 8'h0C, 1'b0};
    // Fairness: req[2] and req[3] together; 3 wins, pointer wraps, then 2.
    vecs[24] = '{4'b1100, 16'h6500, 16'h7500, 4'b1000, 4'b0000, 8'h0C, 1'b1};
    vecs[25] = '{4'b0100, 16'h6500, 16'h7500, 4'b0000, 4'b1000, 8'h2A, 1'b1};
    vecs[26] = '{4'b0100, 16'h6500, 16'h7500, 4'b0000, 4'b0000, 8'h2A, 1'b0};
    vecs[27] = '{4'b0100, 16'h6500, 16'h7500, 4'b0100, 4'b0000, 8'h2A, 1'b1};
    vecs[28] = '{4'b0000, 16'h6500, 16'h7500, 4'b0000, 4'b0100, 8'h19, 1'b1};
    vecs[29] = '{4'b0000, 16'h6500, 16'h7500, 4'b0000, 4'b0000, 8'h19, 1'b0};

    rst    = 1'b1;
    req    = '0;
    a_flat = '0;
    b_flat = '0;
    repeat (2) tick();
    chk("reset gnt",    32'(gnt),    32'h0);
    chk("reset done",   32'(done),   32'h0);
    chk("reset result", 32'(result), 32'h0);
    chk("reset busy",   32'(busy),   32'h0);
    chk_cnt("reset op_count");

    rst = 1'b0;
    tick();
    chk("idle busy", 32'(busy), 32'h0);
    chk("idle gnt",  32'(gnt),  32'h0);

    for (int i = 0; i < NV; i++) begin
      req    = vecs[i].req;
      a_flat = vecs[i].a;
      b_flat = vecs[i].b;
      tick();
      if (vecs[i].done != 4'b0000) exp_cnt++;
      chk($sformatf("row%0d gnt", i),    32'(gnt),    32'(vecs[i].gnt));
      chk($sformatf("row%0d done", i),   32'(done),   32'(vecs[i].done));
      chk($sformatf("row%0d result", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("row%0d busy", i),   32'(busy),   32'(vecs[i].busy));
      chk_cnt($sformatf("row%0d op_count", i));
    end

    // Reset during EXEC for a requester-1 operation (ptr is 3 here).
    req    = 4'b0010;
    a_flat = 16'h0070;
    b_flat = 16'h0030;
    tick();
    chk("pre-reset gnt", 32'(gnt), 32'h2);
    rst = 1'b1;
    req = '0;
    #1;
    chk("midrst gnt",    32'(gnt),    32'h0);
    chk("midrst done",   32'(done),   32'h0);
    chk("midrst result", 32'(result), 32'h0);
    chk("midrst busy",   32'(busy),   32'h0);
    exp_cnt = 0;
    chk_cnt("midrst op_count");
    tick();
    chk("midrst done held", 32'(done), 32'h0);
    rst = 1'b0;

    // Restart at requester 0: req[1] beats req[3].
    req    = 4'b1010;
    a_flat = 16'h2070;
    b_flat = 16'h2030;
    tick();
    chk("post-reset gnt", 32'(gnt), 32'h2);
    req = 4'b1000;
    tick();
    chk("post-reset done",   32'(done),   32'h2);
    chk("post-reset result", 32'(result), 32'h15);
    exp_cnt++;
    chk_cnt("post-reset op_count");
    tick();
    chk("post-reset idle busy", 32'(busy), 32'h0);
    tick();
    chk("post-reset gnt3", 32'(gnt), 32'h8);
    req = '0;
    tick();
    chk("post-reset done3",   32'(done),   32'h8);
    chk("post-reset result3", 32'(result), 32'h04);
    exp_cnt++;
    chk_cnt("post-reset op_count2");
    tick();
    chk("final busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
